// File: rtl/multi_lane_distributer_pkg.sv
// ----------------------------------------------------------------------------
// multi_lane_distributer_pkg
// Shared types and helpers for the multi-lane distributer and its RX merger:
//   - rx_state_t      : RX state encoding (IDLE / OS / MERGE)
//   - DEFAULT_BYTE_W  : default lane symbol width
//   - lanes_legal()   : lane-count legality check (1, 2 or 4)
//   - idx_width()     : width of a lane index register (at least 1 bit)
// ----------------------------------------------------------------------------
package multi_lane_distributer_pkg;

   localparam int unsigned DEFAULT_BYTE_W = 8;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_OS    = 2'd1,
      RX_MERGE = 2'd2
   } rx_state_t;

   function automatic logic lanes_legal(input int unsigned n);
      return (n == 1) || (n == 2) || (n == 4);
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_lane_distributer_lane_merger.sv
// ----------------------------------------------------------------------------
// lane_merger
// RX side of the distributer. In ordered-set mode the lane word is registered
// straight through. In transport mode a lane word is captured into a holding
// register and serialised lane 0 first, one byte per cycle.
// Ports:
//   clk, rst          : clock, async active-high reset
//   i_enable          : receive enable (0 forces IDLE, all outputs 0)
//   i_data_os         : 0 = ordered-set, 1 = transport
//   i_lanes, i_valid  : deskewed lane word and qualifier
//   o_ready           : lane word accepted this cycle when i_valid=1
//   o_lanes           : ordered-set word out (0 in transport mode)
//   o_byte(_valid)    : merged transport byte and qualifier
//   o_lanes_on        : RX data bus enable
//   o_data_os         : registered copy of the RX mode
// ----------------------------------------------------------------------------
module lane_merger
   import multi_lane_distributer_pkg::*;
#(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned BYTE_W    = DEFAULT_BYTE_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_enable,
   input  logic                        i_data_os,
   input  logic [NUM_LANES*BYTE_W-1:0] i_lanes,
   input  logic                        i_valid,
   output logic                        o_ready,
   output logic [NUM_LANES*BYTE_W-1:0] o_lanes,
   output logic [BYTE_W-1:0]           o_byte,
   output logic                        o_byte_valid,
   output logic                        o_lanes_on,
   output logic                        o_data_os
);

   localparam int unsigned IDX_W = idx_width(NUM_LANES);

   rx_state_t                   r_state;
   logic [NUM_LANES*BYTE_W-1:0] r_hold;
   logic [IDX_W-1:0]            r_idx;
   logic [BYTE_W-1:0]           r_byte;
   logic                        r_byte_valid;
   logic                        r_ready;
   logic [NUM_LANES*BYTE_W-1:0] r_lanes;
   logic                        r_lanes_on;
   logic                        r_data_os;

   logic [IDX_W-1:0]            w_next_idx;
   logic [BYTE_W-1:0]           w_next_byte;
   logic                        w_last;
   logic                        w_take;

   // r_idx is the lane currently presented on o_byte
   assign w_next_idx = r_idx + IDX_W'(1);
   assign w_last     = (r_idx == IDX_W'(NUM_LANES - 1));
   assign w_take     = (r_state != RX_IDLE) && r_ready && i_valid;

   // Select the next lane from the holding register (loop keeps selects in range)
   always_comb begin
      w_next_byte = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (IDX_W'(k) == w_next_idx) begin
            w_next_byte = r_hold[k*BYTE_W +: BYTE_W];
         end
      end
   end

   // RX state machine; o_ready is precomputed so it is 1 while empty or
   // while the last lane is on the output, giving back-to-back stripes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RX_IDLE;
         r_hold       <= '0;
         r_idx        <= '0;
         r_byte       <= '0;
         r_byte_valid <= 1'b0;
         r_ready      <= 1'b0;
         r_lanes      <= '0;
         r_lanes_on   <= 1'b0;
         r_data_os    <= 1'b0;
      end else if (!i_enable) begin
         r_state      <= RX_IDLE;
         r_hold       <= '0;
         r_idx        <= '0;
         r_byte       <= '0;
         r_byte_valid <= 1'b0;
         r_ready      <= 1'b0;
         r_lanes      <= '0;
         r_lanes_on   <= 1'b0;
         r_data_os    <= 1'b0;
      end else begin
         r_lanes_on <= 1'b1;
         r_data_os  <= i_data_os;
         if (!i_data_os) begin
            // Ordered-set pass-through; also flushes any stripe in flight
            r_state      <= RX_OS;
            r_lanes      <= i_lanes;
            r_hold       <= '0;
            r_idx        <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_ready      <= 1'b1;
         end else begin
            r_state <= RX_MERGE;
            r_lanes <= '0;
            if (w_take) begin
               r_hold       <= i_lanes;
               r_idx        <= '0;
               r_byte       <= i_lanes[BYTE_W-1:0];
               r_byte_valid <= 1'b1;
               r_ready      <= (NUM_LANES == 1);
            end else if ((r_state == RX_MERGE) && r_byte_valid && !w_last) begin
               r_idx        <= w_next_idx;
               r_byte       <= w_next_byte;
               r_ready      <= (w_next_idx == IDX_W'(NUM_LANES - 1));
            end else begin
               r_hold       <= '0;
               r_idx        <= '0;
               r_byte       <= '0;
               r_byte_valid <= 1'b0;
               r_ready      <= 1'b1;
            end
         end
      end
   end

   assign o_ready      = r_ready;
   assign o_lanes      = r_lanes;
   assign o_byte       = r_byte;
   assign o_byte_valid = r_byte_valid;
   assign o_lanes_on   = r_lanes_on;
   assign o_data_os    = r_data_os;

endmodule

// File: rtl/multi_lane_distributer.sv
// ----------------------------------------------------------------------------
// multi_lane_distributer
// TX: ordered-set words are registered through; transport bytes are striped
//     across NUM_LANES lanes (byte j of a stripe to lane j) and the full
//     stripe is presented for one cycle with tx_valid_o.
// RX: delegated to lane_merger (ordered-set pass-through / byte merge).
// Ports:
//   clk, rst                    : clock, async active-high reset
//   enable_t, enable_r          : TX / RX enables
//   data_os_i                   : 0 = ordered-set, 1 = transport (both sides)
//   tx_byte_i, tx_byte_valid_i  : transport byte in
//   tx_lanes_i                  : ordered-set symbols in
//   tx_lanes_o, tx_valid_o      : lane symbols to encoders
//   enable_enc                  : encoder enable
//   rx_lanes_i, rx_valid_i      : deskewed lanes in;  rx_ready_o : accept
//   rx_lanes_o                  : ordered-set symbols out
//   rx_byte_o, rx_byte_valid_o  : merged transport byte out
//   rx_lanes_on, data_os_o      : RX bus enable, registered RX mode
// ----------------------------------------------------------------------------
module multi_lane_distributer
   import multi_lane_distributer_pkg::*;
#(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned BYTE_W    = DEFAULT_BYTE_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable_t,
   input  logic                        enable_r,
   input  logic                        data_os_i,
   input  logic [BYTE_W-1:0]           tx_byte_i,
   input  logic                        tx_byte_valid_i,
   input  logic [NUM_LANES*BYTE_W-1:0] tx_lanes_i,
   output logic [NUM_LANES*BYTE_W-1:0] tx_lanes_o,
   output logic                        tx_valid_o,
   output logic                        enable_enc,
   input  logic [NUM_LANES*BYTE_W-1:0] rx_lanes_i,
   input  logic                        rx_valid_i,
   output logic                        rx_ready_o,
   output logic [NUM_LANES*BYTE_W-1:0] rx_lanes_o,
   output logic [BYTE_W-1:0]           rx_byte_o,
   output logic                        rx_byte_valid_o,
   output logic                        rx_lanes_on,
   output logic                        data_os_o
);

   localparam int unsigned IDX_W = idx_width(NUM_LANES);

   if (!lanes_legal(NUM_LANES)) begin : g_bad_lanes
      $error("multi_lane_distributer: NUM_LANES must be 1, 2 or 4");
   end

   logic [IDX_W-1:0]            r_tx_idx;
   logic [NUM_LANES*BYTE_W-1:0] r_tx_buf;
   logic [NUM_LANES*BYTE_W-1:0] r_tx_lanes;
   logic                        r_tx_valid;
   logic                        r_enable_enc;

   logic [NUM_LANES*BYTE_W-1:0] w_tx_stripe;
   logic                        w_tx_last;

   assign w_tx_last = (r_tx_idx == IDX_W'(NUM_LANES - 1));

   // Stripe buffer with the incoming byte dropped into the current lane
   always_comb begin
      w_tx_stripe = r_tx_buf;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (IDX_W'(k) == r_tx_idx) begin
            w_tx_stripe[k*BYTE_W +: BYTE_W] = tx_byte_i;
         end
      end
   end

   // TX striping; any cycle in ordered-set mode drops a partial stripe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_idx     <= '0;
         r_tx_buf     <= '0;
         r_tx_lanes   <= '0;
         r_tx_valid   <= 1'b0;
         r_enable_enc <= 1'b0;
      end else if (!enable_t) begin
         r_tx_idx     <= '0;
         r_tx_buf     <= '0;
         r_tx_valid   <= 1'b0;
         r_enable_enc <= 1'b0;
      end else begin
         r_enable_enc <= 1'b1;
         if (!data_os_i) begin
            r_tx_lanes <= tx_lanes_i;
            r_tx_valid <= 1'b1;
            r_tx_idx   <= '0;
            r_tx_buf   <= '0;
         end else begin
            r_tx_valid <= 1'b0;
            if (tx_byte_valid_i) begin
               if (w_tx_last) begin
                  r_tx_lanes <= w_tx_stripe;
                  r_tx_valid <= 1'b1;
                  r_tx_idx   <= '0;
                  r_tx_buf   <= '0;
               end else begin
                  r_tx_buf   <= w_tx_stripe;
                  r_tx_idx   <= r_tx_idx + IDX_W'(1);
               end
            end
         end
      end
   end

   assign tx_lanes_o = r_tx_lanes;
   assign tx_valid_o = r_tx_valid;
   assign enable_enc = r_enable_enc;

   lane_merger #(
      .NUM_LANES (NUM_LANES),
      .BYTE_W    (BYTE_W)
   ) u_lane_merger (
      .clk          (clk),
      .rst          (rst),
      .i_enable     (enable_r),
      .i_data_os    (data_os_i),
      .i_lanes      (rx_lanes_i),
      .i_valid      (rx_valid_i),
      .o_ready      (rx_ready_o),
      .o_lanes      (rx_lanes_o),
      .o_byte       (rx_byte_o),
      .o_byte_valid (rx_byte_valid_o),
      .o_lanes_on   (rx_lanes_on),
      .o_data_os    (data_os_o)
   );

endmodule
